signed_peak_tracker: RTL and testbench
======================================

Name: signed_peak_tracker

Overview:
- Downstream consumer of the 3-bit signed two's-complement max-select stage.
- Accepts a stream of signed samples over a valid/ready handshake and tracks the running signed maximum across a frame of FRAME_LEN samples.
- At the end of each frame, presents the frame peak on a registered valid/ready output port.
- Feeds the display and report logic that follows in the lab datapath.

Parameters:
- WIDTH, 3, sample width; samples are signed two's complement (range -4..3 at default).
- FRAME_LEN, 8, samples per frame; legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- clear  input  1  synchronous frame abort; discards the current frame.
- in_valid  input  1  upstream sample valid.
- in_data  input  WIDTH  signed sample.
- in_ready  output  1  block can accept a sample this cycle.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_peak  output  WIDTH  signed maximum of the completed frame.
- sample_cnt  output  8  samples accepted in the current frame.

Behaviour:
- States:
  - IDLE: no samples in the current frame.
  - ACCUM: at least one sample, frame not complete.
  - DONE: result held for downstream.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - out_valid=0, out_peak=0, sample_cnt=0, internal running peak=0.
  - in_ready=1 from the first cycle after reset deassertion.
- in_ready is decoded from state: 1 in IDLE/ACCUM, 0 in DONE.
- Accept condition: in_valid && in_ready. Samples presented without in_ready are ignored and never counted.
- IDLE accept:
  - Running peak is loaded with in_data, with no comparison.
  - sample_cnt becomes 1.
  - Go to ACCUM, or to DONE if FRAME_LEN==1.
- ACCUM accept:
  - Running peak becomes the signed max(peak, in_data). Ties leave the peak unchanged.
  - Comparison is signed: the MSB is the sign bit. 3'b111 (-1) < 3'b001 (1); 3'b100 (-4) is the minimum.
  - sample_cnt increments.
- Frame completion, on the accept that makes sample_cnt==FRAME_LEN:
  - Next cycle: state=DONE, out_valid=1.
  - out_peak equals the max including that final sample.
  - Latency is 1 cycle from the final accept edge to out_valid.
- DONE:
  - out_peak and out_valid are held stable until out_valid && out_ready.
  - On that handshake: go to IDLE, out_valid=0, sample_cnt=0, and in_ready=1 in the next cycle.
  - out_peak keeps its last value after the handshake; it is only meaningful while out_valid=1.
- No simultaneous sample accept and result handoff: in_ready=0 in DONE, so there is no bypass path.
- clear=1 at a clk edge (rst_n=1):
  - State goes to IDLE, sample_cnt=0, out_valid=0.
  - A pending result in DONE is discarded.
  - A sample offered in the same cycle is dropped, even if in_ready=1.
  - out_peak is unchanged.
- Priority: rst_n > clear > out handshake > sample accept.
- Reset mid-frame or mid-DONE: all state is lost; no partial result is emitted.
- sample_cnt never exceeds FRAME_LEN and never wraps.

Optional Feature:
- Macro: PEAK_TROUGH_EN.
- Defined:
  - Adds output out_trough (WIDTH), the signed minimum of the frame.
  - It is tracked in parallel with identical load, tie, clear and reset rules; reset value 0.
  - It is valid under the same out_valid.
- Undefined:
  - out_trough port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then 8 back-to-back samples {1,-2,3,0,-4,2,1,-1} with out_ready=1 -> out_valid=1 for one cycle, 1 cycle after the 8th accept; out_peak=3'b011. With PEAK_TROUGH_EN: out_trough=3'b100.
- Signed check: frame {-1,1,-1,-1,-1,-1,-1,-1} -> out_peak=3'b001, not 3'b111. Frame of all 3'b100 -> out_peak=3'b100.
- Backpressure: complete a frame with out_ready=0 for 5 cycles while in_valid=1 with data 3 -> in_ready=0; out_valid and out_peak stay stable; sample_cnt stays 8. Raise out_ready -> IDLE next cycle; the next accepted sample starts a new frame with sample_cnt=1.
- Clear mid-frame: after 4 samples (peak 2), assert clear with in_valid=1 and data 3 in the same cycle -> sample dropped, sample_cnt=0. The next 8 samples of value -3 give out_peak=3'b101.
- Reset mid-frame: drive rst_n=0 for 1 cycle after 5 samples -> out_valid=0, sample_cnt=0, out_peak=0, in_ready=1 the following cycle. The next full frame gives a correct peak with no carry-over.
- FRAME_LEN=1 build: every accepted sample yields out_valid the next cycle with out_peak=in_data. in_ready stays low until each handshake.

Source files
------------

// File: rtl/signed_peak_tracker_if.sv
// Sample-in / frame-result-out bundle for signed_peak_tracker; out_trough exists only with PEAK_TROUGH_EN.
// The master modport drives samples and result acceptance; the slave modport is the tracker.
interface signed_peak_tracker_if #(
  parameter int WIDTH = 3
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_peak;
  logic [7:0]       sample_cnt;
`ifdef PEAK_TROUGH_EN
  logic [WIDTH-1:0] out_trough;
`endif

  modport master (
    output clear, in_valid, in_data, out_ready,
`ifdef PEAK_TROUGH_EN
    input  out_trough,
`endif
    input  in_ready, out_valid, out_peak, sample_cnt
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
`ifdef PEAK_TROUGH_EN
    output out_trough,
`endif
    output in_ready, out_valid, out_peak, sample_cnt
  );
endinterface

// File: rtl/signed_peak_tracker.sv
// Running signed max over FRAME_LEN samples (min too with PEAK_TROUGH_EN); result registered 1 cycle after the last accept.
// Backpressure: in_ready drops while a result waits in DONE; no accept/handoff overlap.
module signed_peak_tracker #(
  parameter int WIDTH     = 3,
  parameter int FRAME_LEN = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  signed_peak_tracker_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [7:0] FRAME_LEN_C = FRAME_LEN[7:0];

  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH-1:0]        out_peak_q, out_peak_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] din_s;
  logic signed [WIDTH-1:0] peak_nxt;
  logic [7:0]              cnt_inc;
  logic                    in_ready_w;
  logic                    accept;
  logic                    last;

  assign din_s      = bus.in_data;
  assign in_ready_w = (state_q != DONE);
  assign accept     = bus.in_valid && in_ready_w;
  assign cnt_inc    = cnt_q + 8'd1;
  assign last       = (cnt_inc == FRAME_LEN_C);

  // The first sample of a frame seeds the tracker; ties keep the held value.
  always_comb begin
    peak_nxt = peak_q;
    if (state_q == IDLE || din_s > peak_q) peak_nxt = din_s;
  end

`ifdef PEAK_TROUGH_EN
  logic signed [WIDTH-1:0] trough_q, trough_d, trough_nxt;
  logic [WIDTH-1:0]        out_trough_q, out_trough_d;

  always_comb begin
    trough_nxt = trough_q;
    if (state_q == IDLE || din_s < trough_q) trough_nxt = din_s;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    peak_d      = peak_q;
    out_peak_d  = out_peak_q;
    out_valid_d = out_valid_q;
`ifdef PEAK_TROUGH_EN
    trough_d     = trough_q;
    out_trough_d = out_trough_q;
`endif
    if (bus.clear) begin
      state_d     = IDLE;
      cnt_d       = 8'd0;
      out_valid_d = 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      state_d     = IDLE;
      cnt_d       = 8'd0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      peak_d = peak_nxt;
      cnt_d  = cnt_inc;
`ifdef PEAK_TROUGH_EN
      trough_d = trough_nxt;
`endif
      if (last) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        out_peak_d  = peak_nxt;
`ifdef PEAK_TROUGH_EN
        out_trough_d = trough_nxt;
`endif
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      peak_q      <= '0;
      out_peak_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef PEAK_TROUGH_EN
      trough_q     <= '0;
      out_trough_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      peak_q      <= peak_d;
      out_peak_q  <= out_peak_d;
      out_valid_q <= out_valid_d;
`ifdef PEAK_TROUGH_EN
      trough_q     <= trough_d;
      out_trough_q <= out_trough_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_peak   = out_peak_q;
  assign bus.sample_cnt = cnt_q;
`ifdef PEAK_TROUGH_EN
  assign bus.out_trough = out_trough_q;
`endif
endmodule

// File: tb/tb_signed_peak_tracker.sv
// Directed frames against hand-computed peaks, checked by a handshake-driven scoreboard monitor.
// A second instance with FRAME_LEN=1 covers the single-sample frame case.
module tb_signed_peak_tracker;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] M2 = 3'b110;
  localparam logic [2:0] M3 = 3'b101;
  localparam logic [2:0] M4 = 3'b100;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [2:0] exp_peak_q[$];
  logic [2:0] exp_trough_q[$];

  signed_peak_tracker_if #(.WIDTH(3)) bus  ();
  signed_peak_tracker_if #(.WIDTH(3)) bus1 ();

  signed_peak_tracker #(.WIDTH(3), .FRAME_LEN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  signed_peak_tracker #(.WIDTH(3), .FRAME_LEN(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_result(input logic [2:0] pk, input logic [2:0] tr);
    exp_peak_q.push_back(pk);
    exp_trough_q.push_back(tr);
  endtask

  // Presents one sample for one clock edge; caller guarantees in_ready.
  task automatic send(input logic [2:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every result handshake must match the oldest expectation.
  initial begin
    logic [2:0] ep;
    logic [2:0] et;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_peak_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got peak %0h, expected no result", bus.out_peak);
        end else begin
          ep = exp_peak_q.pop_front();
          et = exp_trough_q.pop_front();
          check("out_peak", {5'd0, bus.out_peak}, {5'd0, ep});
`ifdef PEAK_TROUGH_EN
          check("out_trough", {5'd0, bus.out_trough}, {5'd0, et});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [2:0] f1 [8] = '{3'b001, M2, 3'b011, 3'b000, M4, 3'b010, 3'b001, M1};
  logic [2:0] f2 [8] = '{M1, 3'b001, M1, M1, M1, M1, M1, M1};
  logic [2:0] f5 [8] = '{M4, M3, M2, M1, M4, M4, M4, M4};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = 3'b000; bus.out_ready = 1'b1;
    bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = 3'b000; bus1.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready",   {7'd0, bus.in_ready}, 8'd1);
    check("rst_out_valid",  {7'd0, bus.out_valid}, 8'd0);
    check("rst_sample_cnt", bus.sample_cnt, 8'd0);
    check("rst_out_peak",   {5'd0, bus.out_peak}, 8'd0);

    // Mixed-sign frame: peak 3, trough -4, one-cycle result.
    expect_result(3'b011, M4);
    for (int i = 0; i < 8; i++) send(f1[i]);
    check("f1_out_valid_latency", {7'd0, bus.out_valid}, 8'd1);
    check("f1_sample_cnt_full",   bus.sample_cnt, 8'd8);
    check("f1_in_ready_done",     {7'd0, bus.in_ready}, 8'd0);
    tick();
    check("f1_out_valid_drop", {7'd0, bus.out_valid}, 8'd0);
    check("f1_cnt_cleared",    bus.sample_cnt, 8'd0);
    check("f1_in_ready_back",  {7'd0, bus.in_ready}, 8'd1);

    // Signed ordering: +1 beats -1; all-minimum frame stays at -4.
    expect_result(3'b001, M1);
    for (int i = 0; i < 8; i++) send(f2[i]);
    tick();
    expect_result(M4, M4);
    for (int i = 0; i < 8; i++) send(M4);
    tick();

    // Backpressure with a held sample of 3 that must not be taken.
    bus.out_ready = 1'b0;
    expect_result(M2, M2);
    for (int i = 0; i < 8; i++) send(M2);
    bus.in_valid = 1'b1;
    bus.in_data  = 3'b011;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_in_ready",   {7'd0, bus.in_ready}, 8'd0);
      check("bp_out_valid",  {7'd0, bus.out_valid}, 8'd1);
      check("bp_out_peak",   {5'd0, bus.out_peak}, {5'd0, M2});
      check("bp_sample_cnt", bus.sample_cnt, 8'd8);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", {7'd0, bus.out_valid}, 8'd0);
    check("bp_release_ready", {7'd0, bus.in_ready}, 8'd1);
    send(3'b011);
    check("bp_new_frame_cnt", bus.sample_cnt, 8'd1);

    // Abort that partial frame, then clear mid-frame with a colliding sample.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr1_cnt", bus.sample_cnt, 8'd0);
    send(3'b010); send(3'b000); send(3'b001); send(M1);
    check("pre_clear_cnt", bus.sample_cnt, 8'd4);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 3'b011;
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_cnt",       bus.sample_cnt, 8'd0);
    check("clr_out_valid", {7'd0, bus.out_valid}, 8'd0);
    check("clr_in_ready",  {7'd0, bus.in_ready}, 8'd1);
    expect_result(M3, M3);
    for (int i = 0; i < 8; i++) send(M3);
    tick();

    // Reset mid-frame loses everything; next frame has no carry-over of the 3s.
    for (int i = 0; i < 5; i++) send(3'b011);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_out_valid",  {7'd0, bus.out_valid}, 8'd0);
    check("mrst_sample_cnt", bus.sample_cnt, 8'd0);
    check("mrst_out_peak",   {5'd0, bus.out_peak}, 8'd0);
    check("mrst_in_ready",   {7'd0, bus.in_ready}, 8'd1);
    expect_result(M1, M4);
    for (int i = 0; i < 8; i++) send(f5[i]);
    tick();

    // FRAME_LEN=1 instance: each accept is a complete frame.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 3'b010;
    tick();
    bus1.in_data  = M1;
    check("fl1_valid",    {7'd0, bus1.out_valid}, 8'd1);
    check("fl1_peak",     {5'd0, bus1.out_peak}, 8'd2);
    check("fl1_in_ready", {7'd0, bus1.in_ready}, 8'd0);
    tick();
    check("fl1_hold_valid", {7'd0, bus1.out_valid}, 8'd1);
    check("fl1_hold_peak",  {5'd0, bus1.out_peak}, 8'd2);
    bus1.out_ready = 1'b1;
    tick();
    check("fl1_hs_valid", {7'd0, bus1.out_valid}, 8'd0);
    check("fl1_hs_ready", {7'd0, bus1.in_ready}, 8'd1);
    tick();
    bus1.in_valid = 1'b0;
    check("fl1_2nd_valid", {7'd0, bus1.out_valid}, 8'd1);
    check("fl1_2nd_peak",  {5'd0, bus1.out_peak}, {5'd0, M1});
    tick();
    check("fl1_2nd_done", {7'd0, bus1.out_valid}, 8'd0);

    tick(); tick();
    check("scoreboard_drained", exp_peak_q.size() > 255 ? 8'hff : 8'(exp_peak_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
